// File: rtl/weight_sram_ctrl.sv
// weight_sram_ctrl
//   Shares the single port of the 256x32 weight SRAM between a host write
//   port and a burst read engine feeding the neuron update datapath. The
//   SRAM's one-cycle read latency is absorbed by a 2-entry output FIFO, and
//   the read stream supports full valid/ready backpressure.
//
// Ports
//   CK, RSTB              clock (rising edge, shared with SRAM), async active-low reset
//   wr_valid/wr_ready     host write handshake; wr_addr/wr_data carry the word
//   rd_start/rd_base/rd_cnt  burst request (length = rd_cnt + 1 words)
//   rd_busy               burst in progress
//   rd_data_valid/ready   read stream handshake; rd_data, rd_data_last
//   rd_done               one-cycle pulse after the final word is taken
//   CS, OE, WEB, A, DI    SRAM controls/address/write data (WEB active-low)
//   DO                    SRAM read data, valid the cycle after a read edge
module weight_sram_ctrl #(
    parameter int AW = 8,
    parameter int DW = 32
) (
    input  logic          CK,
    input  logic          RSTB,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_start,
    input  logic [AW-1:0] rd_base,
    input  logic [AW-1:0] rd_cnt,
    output logic          rd_busy,
    output logic          rd_data_valid,
    input  logic          rd_data_ready,
    output logic [DW-1:0] rd_data,
    output logic          rd_data_last,
    output logic          rd_done,
    output logic          CS,
    output logic          OE,
    output logic          WEB,
    output logic [AW-1:0] A,
    output logic [DW-1:0] DI,
    input  logic [DW-1:0] DO
);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_BURST = 1'b1;

    logic [0:0]    r_state;
    logic [AW-1:0] r_base;
    logic [AW-1:0] r_cnt;
    logic [AW:0]   r_issued;        // one bit wider so a full 2^AW burst terminates
    logic          r_inflight;      // a read was issued at the previous edge
    logic          r_inflight_last; // ... and it was the final word of the burst
    logic          r_rd_won;        // last conflicting grant went to the read side
    logic          r_done;
    logic [AW-1:0] r_a;
    logic [DW-1:0] r_di;
    logic [DW-1:0] r_fifo_d [2];
    logic [1:0]    r_fifo_l;
    logic          r_wptr;
    logic          r_rptr;
    logic [1:0]    r_occ;

    logic          w_pop;
    logic          w_fin;
    logic [2:0]    w_slots;
    logic          w_rd_elig;
    logic          w_wr_elig;
    logic          w_gnt_wr;
    logic          w_gnt_rd;
    logic [AW-1:0] w_rd_addr;

    assign w_pop     = rd_data_valid & rd_data_ready;
    assign w_fin     = w_pop & rd_data_last;

    // Words that will occupy the FIFO after this edge if no new read is issued;
    // a read may only be issued when that leaves room for its returning word.
    assign w_slots   = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_rd_elig = (r_state == S_BURST) && (r_issued <= {1'b0, r_cnt}) && (w_slots < 3'd2);
    assign w_wr_elig = wr_valid & RSTB;

    // On a conflict the write wins when the previous conflict went to the read.
    assign w_gnt_wr  = w_wr_elig & (~w_rd_elig | r_rd_won);
    assign w_gnt_rd  = w_rd_elig & ~w_gnt_wr;
    assign w_rd_addr = r_base + r_issued[AW-1:0];

    assign wr_ready  = w_gnt_wr;
    assign CS        = w_gnt_wr | w_gnt_rd;
    assign WEB       = ~w_gnt_wr;
    assign OE        = 1'b1;
    assign A         = w_gnt_wr ? wr_addr : (w_gnt_rd ? w_rd_addr : r_a);
    assign DI        = w_gnt_wr ? wr_data : r_di;

    assign rd_busy       = (r_state == S_BURST);
    assign rd_data_valid = (r_occ != 2'd0);
    assign rd_data       = rd_data_valid ? r_fifo_d[r_rptr] : '0;
    assign rd_data_last  = rd_data_valid & r_fifo_l[r_rptr];
    assign rd_done       = r_done;

    always_ff @(posedge CK or negedge RSTB) begin
        if (!RSTB) begin
            r_state         <= S_IDLE;
            r_base          <= '0;
            r_cnt           <= '0;
            r_issued        <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
            r_rd_won        <= 1'b1;
            r_done          <= 1'b0;
            r_a             <= '0;
            r_di            <= '0;
            r_fifo_l        <= '0;
            r_wptr          <= 1'b0;
            r_rptr          <= 1'b0;
            r_occ           <= '0;
        end else begin
            r_done <= w_fin;
            r_a    <= A;
            r_di   <= DI;

            if (w_gnt_wr && w_rd_elig) begin
                r_rd_won <= 1'b0;
            end else if (w_gnt_rd && w_wr_elig) begin
                r_rd_won <= 1'b1;
            end

            r_inflight      <= w_gnt_rd;
            r_inflight_last <= w_gnt_rd && (r_issued[AW-1:0] == r_cnt);
            if (w_gnt_rd) begin
                r_issued <= r_issued + (AW+1)'(1);
            end

            // DO of the previous edge's read is pushed here.
            if (r_inflight) begin
                r_fifo_l[r_wptr] <= r_inflight_last;
                r_wptr           <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            r_occ <= r_occ + {1'b0, r_inflight} - {1'b0, w_pop};

            case (r_state)
                S_IDLE: begin
                    if (rd_start) begin
                        r_state  <= S_BURST;
                        r_base   <= rd_base;
                        r_cnt    <= rd_cnt;
                        r_issued <= '0;
                    end
                end
                default: begin
                    if (w_fin) begin
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge CK) begin
        if (r_inflight) begin
            r_fifo_d[r_wptr] <= DO;
        end
    end

endmodule

// File: tb/tb_weight_sram_ctrl.sv
// Directed bench for weight_sram_ctrl with a behavioural 256x32 SRAM.
module tb_weight_sram_ctrl;

    logic        CK = 1'b0;
    logic        RSTB = 1'b0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [7:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic        rd_start = 1'b0;
    logic [7:0]  rd_base = '0;
    logic [7:0]  rd_cnt = '0;
    logic        rd_busy;
    logic        rd_data_valid;
    logic        rd_data_ready = 1'b0;
    logic [31:0] rd_data;
    logic        rd_data_last;
    logic        rd_done;
    logic        CS, OE, WEB;
    logic [7:0]  A;
    logic [31:0] DI;
    logic [31:0] DO = '0;

    logic [31:0] mem     [256];
    logic [31:0] exp_mem [256];
    int nvec = 0;
    int nfail = 0;
    int n_rd = 0;
    int n_pop = 0;
    int max_out = 0;

    weight_sram_ctrl #(.AW(8), .DW(32)) dut (
        .CK(CK), .RSTB(RSTB),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_start(rd_start), .rd_base(rd_base), .rd_cnt(rd_cnt), .rd_busy(rd_busy),
        .rd_data_valid(rd_data_valid), .rd_data_ready(rd_data_ready), .rd_data(rd_data),
        .rd_data_last(rd_data_last), .rd_done(rd_done),
        .CS(CS), .OE(OE), .WEB(WEB), .A(A), .DI(DI), .DO(DO)
    );

    always #5 CK = ~CK;

    always @(posedge CK) begin
        if (CS) begin
            if (!WEB) mem[A] <= DI;
            else      DO <= mem[A];
        end
    end

    // Reads issued minus words taken = words buffered or in flight.
    always @(posedge CK or negedge RSTB) begin
        if (!RSTB) begin
            n_rd  = 0;
            n_pop = 0;
        end else begin
            if (CS && WEB) n_rd++;
            if (rd_data_valid && rd_data_ready) n_pop++;
            if (n_rd - n_pop > max_out) max_out = n_rd - n_pop;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals();
        chk("rst_busy",   32'(rd_busy), 32'd0);
        chk("rst_valid",  32'(rd_data_valid), 32'd0);
        chk("rst_last",   32'(rd_data_last), 32'd0);
        chk("rst_done",   32'(rd_done), 32'd0);
        chk("rst_wready", 32'(wr_ready), 32'd0);
        chk("rst_cs",     32'(CS), 32'd0);
        chk("rst_web",    32'(WEB), 32'd1);
        chk("rst_oe",     32'(OE), 32'd1);
        chk("rst_a",      32'(A), 32'd0);
        chk("rst_di",     DI, 32'd0);
        chk("rst_rdata",  rd_data, 32'd0);
    endtask

    // Called at a negative edge.
    task automatic do_write(input logic [7:0] a, input logic [31:0] d);
        int t = 0;
        wr_valid = 1'b1; wr_addr = a; wr_data = d;
        #1;
        while (!wr_ready && t < 50) begin
            @(negedge CK); #1; t++;
        end
        chk("wr_grant", 32'(wr_ready), 32'd1);
        exp_mem[a] = d;
        @(negedge CK);
        wr_valid = 1'b0;
    endtask

    // mode 0: ready held high (latency and throughput checked); mode 1: random
    // ready with a 5-cycle stall. contend holds wr_valid high; restart pulses
    // rd_start mid-burst. Called at a negative edge.
    task automatic run_burst(input logic [7:0] base, input logic [7:0] cnt, input int mode,
                             input bit contend, input bit restart, output int nw);
        int idx = 0;
        int c = 0;
        int first_c = -1;
        int last_c = -1;
        bit wg_prev = 1'b0;
        bit rg_prev = 1'b0;
        bit rg;
        bit bad_alt = 1'b0;
        logic [7:0] ea;
        nw = 0;
        rd_base = base; rd_cnt = cnt; rd_start = 1'b1;
        @(posedge CK);
        @(negedge CK);
        rd_start = 1'b0;
        while (idx <= int'(cnt) && c < 3000) begin
            if (contend) begin
                wr_valid = 1'b1;
                if (wg_prev) begin wr_addr = wr_addr + 8'd1; wr_data = wr_data + 32'd1; end
            end
            if (mode == 1) rd_data_ready = (c >= 10 && c < 15) ? 1'b0 : ($urandom_range(0, 1) == 1);
            else           rd_data_ready = 1'b1;
            if (restart && c == 5) begin rd_start = 1'b1; rd_base = 8'h77; rd_cnt = 8'd3; end
            else rd_start = 1'b0;
            #1;
            if (rd_data_valid && rd_data_ready) begin
                ea = base + 8'(idx);
                chk("burst_data", rd_data, exp_mem[ea]);
                chk("burst_last", 32'(rd_data_last), 32'(idx == int'(cnt)));
                if (first_c < 0) first_c = c;
                last_c = c;
                idx++;
            end
            wg_prev = wr_ready;
            if (wr_ready) begin exp_mem[wr_addr] = wr_data; nw++; end
            rg = CS && WEB;
            if (contend && rg && rg_prev) bad_alt = 1'b1;
            rg_prev = rg;
            @(negedge CK);
            c++;
        end
        wr_valid = 1'b0;
        rd_start = 1'b0;
        rd_data_ready = 1'b0;
        #1;
        chk("burst_complete", 32'(idx), 32'(int'(cnt) + 1));
        chk("done_pulse", 32'(rd_done), 32'd1);
        chk("busy_fall", 32'(rd_busy), 32'd0);
        if (mode == 0 && !contend) begin
            chk("first_latency", 32'(first_c), 32'd2);
            chk("last_cycle", 32'(last_c), 32'(2 + int'(cnt)));
        end
        if (contend) chk("grant_alternate", 32'(bad_alt), 32'd0);
        @(negedge CK);
        chk("done_one_cycle", 32'(rd_done), 32'd0);
    endtask

    initial begin
        int nw;
        int nw_cont;
        // Reset state, with a write request pending to show wr_ready is forced low.
        wr_valid = 1'b1; wr_addr = 8'h33; wr_data = 32'hDEADBEEF;
        #2;
        chk_reset_vals();
        wr_valid = 1'b0;
        @(negedge CK); RSTB = 1'b1;
        @(negedge CK);

        // Load the full array.
        for (int i = 0; i < 256; i++) do_write(8'(i), 32'hA5A50000 + 32'(i));

        // Full 256-word burst, then an address-wrapping burst.
        run_burst(8'd0, 8'd255, 0, 1'b0, 1'b0, nw);
        run_burst(8'd250, 8'd9, 0, 1'b0, 1'b0, nw);

        // Random backpressure with a 5-cycle stall.
        run_burst(8'd16, 8'd63, 1, 1'b0, 1'b0, nw);

        // Contention: writes to 100.. during a 16-word burst from 0, then read them back.
        wr_addr = 8'd100; wr_data = 32'h5A5A0000;
        run_burst(8'd0, 8'd15, 0, 1'b1, 1'b0, nw_cont);
        chk("contend_writes", 32'(nw_cont >= 15), 32'd1);
        run_burst(8'd100, 8'(nw_cont - 1), 0, 1'b0, 1'b0, nw);

        // rd_start pulsed mid-burst is ignored; single-word burst.
        run_burst(8'd40, 8'd20, 0, 1'b0, 1'b1, nw);
        run_burst(8'd7, 8'd0, 0, 1'b0, 1'b0, nw);

        // Reset mid-burst.
        rd_base = 8'd0; rd_cnt = 8'd30; rd_start = 1'b1; rd_data_ready = 1'b1;
        @(posedge CK);
        @(negedge CK);
        rd_start = 1'b0;
        repeat (4) @(negedge CK);
        wr_valid = 1'b1; wr_addr = 8'h44; wr_data = 32'h12345678;
        RSTB = 1'b0;
        #1;
        chk_reset_vals();
        wr_valid = 1'b0; rd_data_ready = 1'b0;
        @(negedge CK); RSTB = 1'b1;
        @(negedge CK);
        run_burst(8'd200, 8'd3, 0, 1'b0, 1'b0, nw);

        chk("max_outstanding", 32'(max_out <= 2), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
